// File: rtl/vram_arb_pkg.sv
// rtl/vram_arb_pkg.sv - shared types and default sizing for the video RAM arbiter
package vram_arb_pkg;

  // Default sizing: 2K x 8 video/bullet RAM, CPU forced through after 3 losses
  localparam int VRAM_AW           = 11;
  localparam int VRAM_DW           = 8;
  localparam int VRAM_STARVE_LIMIT = 3;

  // RAM port sequencer: ADDR is the cycle the RAM sees the address, DATA the read-data cycle
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } arb_state_t;

  // Which requester owns the access currently on the RAM port
  typedef enum logic {
    OWN_VID = 1'b0,
    OWN_CPU = 1'b1
  } arb_owner_t;

  // Outcome of one arbitration decision
  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_VID  = 2'd1,
    GNT_CPU  = 2'd2
  } arb_grant_t;

endpackage

// File: rtl/vram_arbiter.sv
// rtl/vram_arbiter.sv - single-port video RAM shared between display fetch and 6502 CPU
module vram_arbiter
  import vram_arb_pkg::*;
#(
  parameter int AW           = VRAM_AW,
  parameter int DW           = VRAM_DW,
  parameter int STARVE_LIMIT = VRAM_STARVE_LIMIT
) (
  input  logic          CLK_18M,
  input  logic          RESET_n,
  input  logic          vid_req,
  input  logic [AW-1:0] vid_addr,
  output logic [DW-1:0] vid_data,
  output logic          vid_valid,
  output logic          vid_overrun,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_ack,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata
);

  localparam int            CW         = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] STARVE_MAX = CW'(STARVE_LIMIT);

  // Display fetches win unless the CPU has lost too many times in a row
  function automatic arb_grant_t arbitrate(input logic starved,
                                           input logic vid_pending,
                                           input logic cpu_pending);
    arb_grant_t result;
    result = GNT_NONE;
    if (starved && cpu_pending) begin
      result = GNT_CPU;
    end else if (vid_pending) begin
      result = GNT_VID;
    end else if (cpu_pending) begin
      result = GNT_CPU;
    end
    return result;
  endfunction

  arb_state_t    state_q;
  arb_state_t    state_d;
  arb_owner_t    owner_q;
  logic          vid_pend_q;
  logic [AW-1:0] vaddr_q;
  logic [CW-1:0] starve_q;

  logic          cpu_busy;
  logic          cpu_pend;
  logic          grant_pt;
  arb_grant_t    grant;
  logic          vid_done;
  logic          cpu_rd_done;
  logic          cpu_wr_done;
  logic          overrun_d;

  // Grant decision; ram_we doubles as the "current access is a write" flag during ADDR
  always_comb begin
    cpu_busy = (state_q != IDLE) && (owner_q == OWN_CPU);
    cpu_pend = cpu_req && !cpu_busy;
    grant_pt = (state_q == IDLE) || (state_q == DATA) || ((state_q == ADDR) && ram_we);
    grant    = GNT_NONE;
    if (grant_pt) begin
      grant = arbitrate(starve_q >= STARVE_MAX, vid_pend_q, cpu_pend);
    end
  end

  // State register
  always_ff @(posedge CLK_18M or negedge RESET_n) begin
    if (!RESET_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: a read always spends one cycle in DATA, writes can chain from ADDR
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = (grant != GNT_NONE) ? ADDR : IDLE;
      ADDR: begin
        if (!ram_we) begin
          state_d = DATA;
        end else begin
          state_d = (grant != GNT_NONE) ? ADDR : IDLE;
        end
      end
      DATA:    state_d = (grant != GNT_NONE) ? ADDR : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Completion and overrun conditions decoded from the current state
  always_comb begin
    vid_done    = (state_q == DATA) && (owner_q == OWN_VID);
    cpu_rd_done = (state_q == DATA) && (owner_q == OWN_CPU);
    cpu_wr_done = (state_q == ADDR) && (owner_q == OWN_CPU) && ram_we;
    overrun_d   = vid_req && vid_pend_q && (grant != GNT_VID);
  end

  // RAM port registers, loaded on every grant; the write strobe lasts one cycle
  always_ff @(posedge CLK_18M or negedge RESET_n) begin
    if (!RESET_n) begin
      ram_addr  <= '0;
      ram_we    <= 1'b0;
      ram_wdata <= '0;
      owner_q   <= OWN_VID;
    end else begin
      ram_we <= 1'b0;
      case (grant)
        GNT_VID: begin
          owner_q  <= OWN_VID;
          ram_addr <= vaddr_q;
        end
        GNT_CPU: begin
          owner_q  <= OWN_CPU;
          ram_addr <= cpu_addr;
          ram_we   <= cpu_we;
          if (cpu_we) begin
            ram_wdata <= cpu_wdata;
          end
        end
        default: ;
      endcase
    end
  end

  // Single-entry fetch latch: a new strobe replaces an unserved one and flags it
  always_ff @(posedge CLK_18M or negedge RESET_n) begin
    if (!RESET_n) begin
      vid_pend_q  <= 1'b0;
      vaddr_q     <= '0;
      vid_overrun <= 1'b0;
    end else begin
      vid_overrun <= overrun_d;
      if (grant == GNT_VID) begin
        vid_pend_q <= 1'b0;
      end
      if (vid_req) begin
        vid_pend_q <= 1'b1;
        vaddr_q    <= vid_addr;
      end
    end
  end

  // Count consecutive arbitrations the CPU lost to video; any CPU grant clears it
  always_ff @(posedge CLK_18M or negedge RESET_n) begin
    if (!RESET_n) begin
      starve_q <= '0;
    end else if (grant == GNT_CPU) begin
      starve_q <= '0;
    end else if ((grant == GNT_VID) && cpu_pend && (starve_q < STARVE_MAX)) begin
      starve_q <= starve_q + 1'b1;
    end
  end

  // Return read bytes to their owner and pulse the matching completion
  always_ff @(posedge CLK_18M or negedge RESET_n) begin
    if (!RESET_n) begin
      vid_data  <= '0;
      vid_valid <= 1'b0;
      cpu_rdata <= '0;
      cpu_ack   <= 1'b0;
    end else begin
      vid_valid <= vid_done;
      cpu_ack   <= cpu_rd_done || cpu_wr_done;
      if (vid_done) begin
        vid_data <= ram_rdata;
      end
      if (cpu_rd_done) begin
        cpu_rdata <= ram_rdata;
      end
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// tb/tb_vram_arbiter.sv - randomized self-checking bench for vram_arbiter
module tb_vram_arbiter;

  localparam int AW  = 11;
  localparam int DW  = 8;
  localparam int LIM = 3;

  logic          CLK_18M = 1'b0;
  logic          RESET_n = 1'b0;
  logic          vid_req = 1'b0;
  logic [AW-1:0] vid_addr = '0;
  logic [DW-1:0] vid_data;
  logic          vid_valid;
  logic          vid_overrun;
  logic          cpu_req = 1'b0;
  logic          cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_ack;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata = '0;

  vram_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(LIM)) dut (
    .CLK_18M(CLK_18M), .RESET_n(RESET_n),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_data(vid_data),
    .vid_valid(vid_valid), .vid_overrun(vid_overrun),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  always #5 CLK_18M = ~CLK_18M;

  // Synchronous single-port RAM macro with a preload port
  logic [DW-1:0] mem [0:2047];
  logic          pl_en = 1'b0;
  logic [AW-1:0] pl_addr = '0;
  logic [DW-1:0] pl_data = '0;

  always @(posedge CLK_18M) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  // Reference model: the port is a resource with a "free at" time stamp,
  // each grant schedules its visible results a fixed number of cycles later
  logic [DW-1:0] shadow [0:2047];
  int            cyc;
  bit            m_vpend;
  logic [AW-1:0] m_vaddr;
  int            m_free_at;
  int            m_cblk;
  int            m_starve;
  bit            m_cgnt;

  bit            e_vv  [16];
  logic [DW-1:0] e_vd  [16];
  bit            e_ack [16];
  bit            e_rdu [16];
  logic [DW-1:0] e_rd  [16];
  bit            e_we  [16];
  logic [AW-1:0] e_wa  [16];
  logic [DW-1:0] e_wd  [16];
  bit            e_ov  [16];
  logic [DW-1:0] h_vd;
  logic [DW-1:0] h_rd;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
  endtask

  task automatic clear_slot(input int s);
    e_vv[s] = 0; e_vd[s] = '0; e_ack[s] = 0; e_rdu[s] = 0; e_rd[s] = '0;
    e_we[s] = 0; e_wa[s] = '0; e_wd[s] = '0; e_ov[s] = 0;
  endtask

  task automatic model_reset();
    for (int s = 0; s < 16; s++) clear_slot(s);
    m_vpend = 0; m_vaddr = '0; m_free_at = 0; m_cblk = 0; m_starve = 0; m_cgnt = 0;
    h_vd = '0; h_rd = '0;
  endtask

  // One rising edge (the edge that ends cycle t) worth of arbitration rules
  task automatic model_step(input int t);
    bit cpend, gp, gv, gc;
    int s1, s2, s3;
    if (!RESET_n) begin
      model_reset();
      return;
    end
    s1 = (t + 1) % 16; s2 = (t + 2) % 16; s3 = (t + 3) % 16;
    cpend = cpu_req && (t >= m_cblk);
    gp = (t >= m_free_at);
    gv = 0; gc = 0;
    if (gp) begin
      if (m_starve >= LIM && cpend) gc = 1;
      else if (m_vpend) gv = 1;
      else if (cpend) gc = 1;
    end
    if (gv) begin
      if (cpend && m_starve < LIM) m_starve++;
      e_vv[s3] = 1; e_vd[s3] = shadow[m_vaddr];
      m_vpend = 0; m_free_at = t + 2;
    end else if (gc) begin
      m_starve = 0; m_cgnt = 1;
      if (cpu_we) begin
        shadow[cpu_addr] = cpu_wdata;
        e_we[s1] = 1; e_wa[s1] = cpu_addr; e_wd[s1] = cpu_wdata;
        e_ack[s2] = 1;
        m_free_at = t + 1; m_cblk = t + 2;
      end else begin
        e_ack[s3] = 1; e_rdu[s3] = 1; e_rd[s3] = shadow[cpu_addr];
        m_free_at = t + 2; m_cblk = t + 3;
      end
    end
    if (vid_req) begin
      if (m_vpend) e_ov[s1] = 1;
      m_vpend = 1; m_vaddr = vid_addr;
    end
  endtask

  // Every cycle: DUT outputs against the model's schedule
  task automatic compare_cycle();
    int s;
    s = cyc % 16;
    if (e_vv[s]) h_vd = e_vd[s];
    if (e_ack[s] && e_rdu[s]) h_rd = e_rd[s];
    check("vid_valid", vid_valid, e_vv[s]);
    check("vid_data", vid_data, h_vd);
    check("vid_overrun", vid_overrun, e_ov[s]);
    check("cpu_ack", cpu_ack, e_ack[s]);
    check("cpu_rdata", cpu_rdata, h_rd);
    check("ram_we", ram_we, e_we[s]);
    if (e_we[s]) begin
      check("ram_addr_wr", ram_addr, e_wa[s]);
      check("ram_wdata", ram_wdata, e_wd[s]);
    end
    clear_slot(s);
  endtask

  task automatic tick(input logic vr, input logic [AW-1:0] va, input logic cr,
                      input logic cw, input logic [AW-1:0] ca, input logic [DW-1:0] cd);
    @(negedge CLK_18M);
    compare_cycle();
    vid_req = vr; vid_addr = va;
    cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
    model_step(cyc);
    cyc++;
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b0, '0, 1'b0, 1'b0, '0, '0);
  endtask

  logic          cr_r, cw_r, vr_r;
  logic [AW-1:0] ca_r, va_r;
  logic [DW-1:0] cd_r;
  logic [DW-1:0] saved;

  initial begin
    cyc = 0;
    model_reset();
    // Preload RAM (and its shadow) while reset is held
    for (int a = 0; a < 2048; a++) begin
      @(negedge CLK_18M);
      pl_en = 1'b1; pl_addr = AW'(a);
      pl_data = (a == 'h123) ? 8'hA5 : DW'($urandom_range(0, 255));
      shadow[a] = pl_data;
    end
    @(negedge CLK_18M);
    pl_en = 1'b0;

    check("rst_vid_data", vid_data, 0);
    check("rst_vid_valid", vid_valid, 0);
    check("rst_vid_overrun", vid_overrun, 0);
    check("rst_cpu_rdata", cpu_rdata, 0);
    check("rst_cpu_ack", cpu_ack, 0);
    check("rst_ram_addr", ram_addr, 0);
    check("rst_ram_we", ram_we, 0);
    check("rst_ram_wdata", ram_wdata, 0);

    RESET_n = 1'b1;
    idle(3);

    // Isolated video fetch of 0x123
    tick(1'b1, 11'h123, 1'b0, 1'b0, '0, '0);
    idle(4);
    check("vfetch_valid_c4", vid_valid, 1);
    check("vfetch_data_c4", vid_data, 8'hA5);
    idle(1);
    check("vfetch_valid_c5", vid_valid, 0);
    check("vfetch_data_held", vid_data, 8'hA5);

    // CPU write 0x3C to 0x7FF
    idle(2);
    tick(1'b0, '0, 1'b1, 1'b1, 11'h7FF, 8'h3C);
    tick(1'b0, '0, 1'b1, 1'b1, 11'h7FF, 8'h3C);
    check("wr_ram_we_c1", ram_we, 1);
    check("wr_ram_addr_c1", ram_addr, 11'h7FF);
    tick(1'b0, '0, 1'b0, 1'b0, '0, '0);
    check("wr_ack_c2", cpu_ack, 1);
    check("wr_ram_we_c2", ram_we, 0);

    // CPU read back from 0x7FF
    idle(2);
    repeat (3) tick(1'b0, '0, 1'b1, 1'b0, 11'h7FF, '0);
    tick(1'b0, '0, 1'b0, 1'b0, '0, '0);
    check("rd_ack_c3", cpu_ack, 1);
    check("rd_data_c3", cpu_rdata, 8'h3C);

    // Video and CPU contend at one grant point: video first
    idle(2);
    tick(1'b1, 11'h123, 1'b0, 1'b0, '0, '0);
    repeat (4) tick(1'b0, '0, 1'b1, 1'b0, 11'h7FF, '0);
    check("sim_vvalid_c4", vid_valid, 1);
    check("sim_ack_c4", cpu_ack, 0);
    tick(1'b0, '0, 1'b1, 1'b0, 11'h7FF, '0);
    tick(1'b0, '0, 1'b0, 1'b0, '0, '0);
    check("sim_ack_c6", cpu_ack, 1);
    check("sim_rdata_c6", cpu_rdata, 8'h3C);

    // Starvation guard: video every 2 clocks, CPU held until acked
    idle(3);
    for (int i = 0; i < 14; i++) begin
      tick((i % 2) == 0, AW'(11'h100 + i), (i >= 1) && (i <= 9), 1'b0, 11'h123, '0);
      if (i == 9)  check("starve_overrun_c9", vid_overrun, 1);
      if (i == 10) check("starve_cpu_ack_c10", cpu_ack, 1);
      if (i == 10) check("starve_rdata_c10", cpu_rdata, 8'hA5);
      if (i == 12) check("starve_vvalid_c12", vid_valid, 1);
    end

    // Overrun while a CPU read sits in ADDR
    idle(3);
    tick(1'b1, 11'h0AA, 1'b1, 1'b0, 11'h123, '0);
    tick(1'b1, 11'h7FF, 1'b1, 1'b0, 11'h123, '0);
    tick(1'b0, '0, 1'b1, 1'b0, 11'h123, '0);
    check("ovr_pulse_c2", vid_overrun, 1);
    tick(1'b0, '0, 1'b0, 1'b0, '0, '0);
    check("ovr_pulse_c3", vid_overrun, 0);
    check("ovr_cpu_ack_c3", cpu_ack, 1);
    idle(2);
    check("ovr_vvalid_c5", vid_valid, 1);
    check("ovr_vdata_c5", vid_data, 8'h3C);

    // Randomized traffic; second half floods the video side
    idle(3);
    cr_r = 0; cw_r = 0; ca_r = '0; cd_r = '0;
    for (int i = 0; i < 3000; i++) begin
      if (cr_r) begin
        if (e_ack[cyc % 16]) cr_r = 0;
        else if (!m_cgnt && $urandom_range(0, 19) == 0) cr_r = 0;
      end else if ($urandom_range(0, 2) == 0) begin
        cr_r = 1;
        cw_r = 1'($urandom_range(0, 1));
        ca_r = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 15)) : AW'($urandom_range(0, 2047));
        cd_r = DW'($urandom_range(0, 255));
        m_cgnt = 0;
      end
      vr_r = (i < 1500) ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 1) == 0);
      va_r = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 15)) : AW'($urandom_range(0, 2047));
      tick(vr_r, va_r, cr_r, cw_r, ca_r, cd_r);
    end

    // Reset in the ADDR cycle of a write: access abandoned
    idle(6);
    saved = shadow[11'h055];
    tick(1'b0, '0, 1'b1, 1'b1, 11'h055, 8'h99);
    tick(1'b0, '0, 1'b1, 1'b1, 11'h055, 8'h99);
    check("mid_ram_we_before", ram_we, 1);
    RESET_n = 1'b0;
    #1;
    model_reset();
    shadow[11'h055] = saved;
    check("mid_ram_we_async", ram_we, 0);
    check("mid_ram_addr", ram_addr, 0);
    check("mid_cpu_ack", cpu_ack, 0);
    check("mid_vid_data", vid_data, 0);
    check("mid_cpu_rdata", cpu_rdata, 0);
    idle(2);
    RESET_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      idle(1);
      check("post_rst_no_ack", cpu_ack, 0);
    end
    // The abandoned write must not have reached the RAM
    tick(1'b0, '0, 1'b1, 1'b0, 11'h055, '0);
    repeat (2) tick(1'b0, '0, 1'b1, 1'b0, 11'h055, '0);
    tick(1'b0, '0, 1'b0, 1'b0, '0, '0);
    check("post_rst_rd_ack", cpu_ack, 1);
    check("post_rst_rd_data", cpu_rdata, saved);
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
